// File: rtl/detector_colisao.sv
// detector_colisao: once-per-frame shot/enemy collision test, score keeping
// and enemy life cycle (alive -> test -> exploding -> dead).
// Optional feature: define COLISAO_JOGADOR_EN to also test the player
// rectangle against the enemy and track lives / game over.
// estado_dbg exposes the FSM state (0 VIVO, 1 TESTE, 2 EXPLODINDO, 3 MORTO).
`timescale 1ns/1ps
module detector_colisao #(
   parameter int PONTOS_POR_ACERTO = 10,
   parameter int EXPLOSAO_QUADROS  = 30,
   parameter int TIRO_LARGURA      = 2,
   parameter int TIRO_ALTURA       = 6
`ifdef COLISAO_JOGADOR_EN
   ,
   parameter int VIDAS_INICIAIS    = 3
`endif
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        reiniciarJogo,
   input  logic        pausa,
   input  logic        quadro,
   input  logic [9:0]  inimigoX,
   input  logic [9:0]  inimigoY,
   input  logic [9:0]  inimigoLargura,
   input  logic [9:0]  inimigoAltura,
   input  logic [9:0]  tiroX,
   input  logic [9:0]  tiroY,
   input  logic        tiroAtivo,
   output logic        acerto,
   output logic        consumirTiro,
   output logic        inimigoVivo,
   output logic        explodindo,
   output logic [13:0] pontos,
`ifdef COLISAO_JOGADOR_EN
   input  logic [9:0]  jogadorX,
   input  logic [9:0]  jogadorY,
   input  logic [9:0]  jogadorLargura,
   input  logic [9:0]  jogadorAltura,
   output logic [1:0]  vidas,
   output logic        perdeuVida,
   output logic        fimDeJogo,
`endif
   output logic [1:0]  estado_dbg
);

   typedef enum logic [1:0] {
      VIVO       = 2'd0,
      TESTE      = 2'd1,
      EXPLODINDO = 2'd2,
      MORTO      = 2'd3
   } estado_t;

   localparam logic [13:0] PONTOS_MAX = 14'd9999;
   localparam logic [7:0]  CNT_INI    = 8'(EXPLOSAO_QUADROS);

   // Strict AABB overlap in 11-bit arithmetic; empty rectangles never overlap
   // and rectangles that merely touch along an edge do not count.
   function automatic logic sobrepoe(input logic [9:0] ax, ay, aw, ah,
                                     input logic [9:0] bx, by, bw, bh);
      sobrepoe = (aw != 10'd0) && (ah != 10'd0) && (bw != 10'd0) && (bh != 10'd0)
              && ({1'b0, ax} < ({1'b0, bx} + {1'b0, bw}))
              && ({1'b0, bx} < ({1'b0, ax} + {1'b0, aw}))
              && ({1'b0, ay} < ({1'b0, by} + {1'b0, bh}))
              && ({1'b0, by} < ({1'b0, ay} + {1'b0, ah}));
   endfunction

   estado_t     estado_q, estado_d;
   logic        hit_q, hit_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [13:0] pontos_q, pontos_d;
   logic        acerto_q, acerto_d;
   logic        consumir_q, consumir_d;
   logic        vivo_q, vivo_d;
   logic        explodindo_q, explodindo_d;

   logic        aceita;
   logic        acerto_tiro;
   logic [14:0] soma;
   logic [13:0] pontos_sat;

`ifdef COLISAO_JOGADOR_EN
   logic [1:0]  vidas_q, vidas_d;
   logic        perdeu_q, perdeu_d;
   logic        fim_q, fim_d;
   logic        colide_jog;
   logic [1:0]  vidas_menos;
`endif

   // Frame acceptance, collision terms and saturated score.
   // The decision is taken on the operands captured with quadro, so the
   // strobes and the new score are already registered during TESTE.
   always_comb begin
`ifdef COLISAO_JOGADOR_EN
      aceita      = quadro && !pausa && !fim_q;
      colide_jog  = sobrepoe(jogadorX, jogadorY, jogadorLargura, jogadorAltura,
                             inimigoX, inimigoY, inimigoLargura, inimigoAltura);
      vidas_menos = (vidas_q == 2'd0) ? 2'd0 : vidas_q - 2'd1;
`else
      aceita      = quadro && !pausa;
`endif
      acerto_tiro = tiroAtivo &&
                    sobrepoe(tiroX, tiroY, 10'(TIRO_LARGURA), 10'(TIRO_ALTURA),
                             inimigoX, inimigoY, inimigoLargura, inimigoAltura);
      soma        = {1'b0, pontos_q} + 15'(PONTOS_POR_ACERTO);
      pontos_sat  = (soma > {1'b0, PONTOS_MAX}) ? PONTOS_MAX : soma[13:0];
   end

   // Next-state and registered-output logic of the enemy FSM.
   always_comb begin
      estado_d     = estado_q;
      hit_d        = hit_q;
      cnt_d        = cnt_q;
      pontos_d     = pontos_q;
      acerto_d     = 1'b0;
      consumir_d   = 1'b0;
      vivo_d       = vivo_q;
      explodindo_d = explodindo_q;
`ifdef COLISAO_JOGADOR_EN
      vidas_d      = vidas_q;
      perdeu_d     = 1'b0;
      fim_d        = fim_q;
`endif
      case (estado_q)
         VIVO: begin
            if (aceita) begin
               estado_d = TESTE;
`ifdef COLISAO_JOGADOR_EN
               hit_d    = acerto_tiro || colide_jog;
`else
               hit_d    = acerto_tiro;
`endif
               if (acerto_tiro) begin
                  acerto_d     = 1'b1;
                  consumir_d   = 1'b1;
                  pontos_d     = pontos_sat;
                  cnt_d        = CNT_INI;
                  explodindo_d = 1'b1;
               end
`ifdef COLISAO_JOGADOR_EN
               else if (colide_jog) begin
                  perdeu_d     = 1'b1;
                  vidas_d      = vidas_menos;
                  fim_d        = fim_q || (vidas_menos == 2'd0);
                  cnt_d        = CNT_INI;
                  explodindo_d = 1'b1;
               end
`endif
            end
         end
         TESTE: begin
            estado_d = hit_q ? EXPLODINDO : VIVO;
         end
         EXPLODINDO: begin
            if (aceita) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  estado_d     = MORTO;
                  vivo_d       = 1'b0;
                  explodindo_d = 1'b0;
               end
            end
         end
         MORTO: begin
         end
         default: begin
            estado_d = VIVO;
         end
      endcase
   end

   // State and output registers; restart behaves exactly like reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset || reiniciarJogo) begin
         estado_q     <= VIVO;
         hit_q        <= 1'b0;
         cnt_q        <= 8'd0;
         pontos_q     <= 14'd0;
         acerto_q     <= 1'b0;
         consumir_q   <= 1'b0;
         vivo_q       <= 1'b1;
         explodindo_q <= 1'b0;
`ifdef COLISAO_JOGADOR_EN
         vidas_q      <= 2'(VIDAS_INICIAIS);
         perdeu_q     <= 1'b0;
         fim_q        <= 1'b0;
`endif
      end else begin
         estado_q     <= estado_d;
         hit_q        <= hit_d;
         cnt_q        <= cnt_d;
         pontos_q     <= pontos_d;
         acerto_q     <= acerto_d;
         consumir_q   <= consumir_d;
         vivo_q       <= vivo_d;
         explodindo_q <= explodindo_d;
`ifdef COLISAO_JOGADOR_EN
         vidas_q      <= vidas_d;
         perdeu_q     <= perdeu_d;
         fim_q        <= fim_d;
`endif
      end
   end

   assign acerto       = acerto_q;
   assign consumirTiro = consumir_q;
   assign inimigoVivo  = vivo_q;
   assign explodindo   = explodindo_q;
   assign pontos       = pontos_q;
   assign estado_dbg   = estado_q;
`ifdef COLISAO_JOGADOR_EN
   assign vidas        = vidas_q;
   assign perdeuVida   = perdeu_q;
   assign fimDeJogo    = fim_q;
`endif

endmodule
